// File: rtl/weight_index_sequencer_if.sv
// Descriptor stream from the weight-index sequencer to the weight-value memory / PE array.
// The master drives the nonzero descriptors; the slave returns out_ready.
interface weight_index_sequencer_if #(
  parameter int ADDR_W     = 7,
  parameter int VAL_ADDR_W = 12
);
  logic                  out_valid;
  logic                  out_ready;
  logic [VAL_ADDR_W-1:0] out_val_addr;
  logic [2:0]            out_row;
  logic [ADDR_W-1:0]     out_kernel;
  logic                  out_last_in_row;
  logic                  out_last_in_kernel;

  modport master (
    output out_valid,
    output out_val_addr,
    output out_row,
    output out_kernel,
    output out_last_in_row,
    output out_last_in_kernel,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_val_addr,
    input  out_row,
    input  out_kernel,
    input  out_last_in_row,
    input  out_last_in_kernel,
    output out_ready
  );
endinterface

// File: rtl/weight_index_sequencer.sv
// Expands CSR row-pointer words from the index ROM into one fetch descriptor per
// nonzero weight of each 5x5 kernel in a requested range.
module weight_index_sequencer #(
  parameter int NUM_KERNELS = 102,
  parameter int ADDR_W      = 7,
  parameter int VAL_ADDR_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     kernel_first,
  input  logic [ADDR_W-1:0]     kernel_last,
  input  logic [VAL_ADDR_W-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [47:0]           rom_data,
  weight_index_sequencer_if.master desc
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    EMIT,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]     k;
  logic [ADDR_W-1:0]     last;
  logic [ADDR_W-1:0]     last_clamped;
  logic [VAL_ADDR_W-1:0] base;
  logic [7:0]            ptr [6];
  logic [2:0]            r;
  logic [7:0]            j;
  logic [7:0]            row_end;
  logic                  row_has_elem;
  logic                  emit_valid;

  // An inverted range collapses to kernel_first; anything past the ROM is clamped.
  always_comb begin
    last_clamped = kernel_last;
    if (kernel_last < kernel_first) begin
      last_clamped = kernel_first;
    end
    if (32'(kernel_last) >= NUM_KERNELS) begin
      last_clamped = ADDR_W'(NUM_KERNELS - 1);
    end
  end

  always_comb begin
    row_end = ptr[5];
    case (r)
      3'd0:    row_end = ptr[1];
      3'd1:    row_end = ptr[2];
      3'd2:    row_end = ptr[3];
      3'd3:    row_end = ptr[4];
      default: row_end = ptr[5];
    endcase
  end

  // Empty and non-monotone rows both fall out of the same j < end test.
  assign row_has_elem = (j < row_end);
  assign emit_valid   = (state == EMIT) && row_has_elem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        rom_en    = 1'b1;
        rom_addr  = k;
        state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = EMIT;
      end
      EMIT: begin
        if (!row_has_elem && (r == 3'd4)) begin
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        // k never passes last for in-range requests; >= keeps odd ranges finite.
        state_nxt = (k >= last) ? DONE : REQ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= '0;
      last <= '0;
      base <= '0;
      r    <= '0;
      j    <= '0;
      for (int i = 0; i < 6; i++) begin
        ptr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k    <= kernel_first;
            last <= last_clamped;
            base <= base_addr;
          end
        end
        LOAD: begin
          for (int i = 0; i < 6; i++) begin
            ptr[i] <= rom_data[47-8*i -: 8];
          end
          r <= '0;
          j <= rom_data[47:40];
        end
        EMIT: begin
          if (row_has_elem) begin
            if (desc.out_ready) begin
              j <= j + 8'd1;
            end
          end else if (r != 3'd4) begin
            r <= r + 3'd1;
          end
        end
        NEXT: begin
          base <= base + VAL_ADDR_W'(ptr[5]);
          if (k < last) begin
            k <= k + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Descriptor fields come straight from registers so they hold while stalled.
  assign desc.out_valid          = emit_valid;
  assign desc.out_val_addr       = base + VAL_ADDR_W'(j);
  assign desc.out_row            = r;
  assign desc.out_kernel         = k;
  assign desc.out_last_in_row    = emit_valid && (({1'b0, j} + 9'd1) == {1'b0, row_end});
  assign desc.out_last_in_kernel = emit_valid && (({1'b0, j} + 9'd1) == {1'b0, ptr[5]});

endmodule

// File: tb/tb_weight_index_sequencer.sv
// Self-checking bench for weight_index_sequencer: hand-derived vectors, a
// behavioural CSR expansion model, randomized ranges/backpressure and reset cases.
module tb_weight_index_sequencer;

  localparam int NUM_K = 102;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  row;
    logic [6:0]  kernel;
    logic        lir;
    logic        lik;
  } desc_t;

  typedef struct {
    logic [6:0]  first;
    logic [6:0]  last;
    logic [11:0] base;
    int          mode;
    int          exp_count;
    int          exp_done;
    int          exp_first_addr;
    int          exp_first_valid;
    int          exp_last_rom;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  kernel_first;
  logic [6:0]  kernel_last;
  logic [11:0] base_addr;
  logic        busy;
  logic        done;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [47:0] rom_data;

  weight_index_sequencer_if #(.ADDR_W(7), .VAL_ADDR_W(12)) dif ();

  weight_index_sequencer #(.NUM_KERNELS(NUM_K), .ADDR_W(7), .VAL_ADDR_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kernel_first (kernel_first),
    .kernel_last  (kernel_last),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .desc         (dif)
  );

  logic [47:0] rom_mem [128];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          prev_stall = 0;
  int          n_hs = 0;
  int          done_cnt = 0;
  logic [6:0]  last_rom = '0;
  desc_t       exp_q[$];
  desc_t       obs_q[$];
  logic [6:0]  exp_rom_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ROM with one cycle of latency.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rom_en"}, rom_en, 0);
    checkOutput({tag, "_rom_addr"}, rom_addr, 0);
    checkOutput({tag, "_valid"}, dif.out_valid, 0);
    checkOutput({tag, "_val_addr"}, dif.out_val_addr, 0);
    checkOutput({tag, "_row"}, dif.out_row, 0);
    checkOutput({tag, "_kernel"}, dif.out_kernel, 0);
    checkOutput({tag, "_lir"}, dif.out_last_in_row, 0);
    checkOutput({tag, "_lik"}, dif.out_last_in_kernel, 0);
  endtask

  // Scoreboard: every valid cycle must show the oldest outstanding descriptor.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) checkOutput("stall_valid_held", dif.out_valid, 1);
      if (dif.out_valid) begin
        checkOutput("desc_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          checkOutput("val_addr", dif.out_val_addr, exp_q[0].addr);
          checkOutput("row", dif.out_row, exp_q[0].row);
          checkOutput("kernel", dif.out_kernel, exp_q[0].kernel);
          checkOutput("last_in_row", dif.out_last_in_row, exp_q[0].lir);
          checkOutput("last_in_kernel", dif.out_last_in_kernel, exp_q[0].lik);
          if (dif.out_ready) begin
            obs_q.push_back(exp_q.pop_front());
            n_hs++;
          end
        end
      end
      prev_stall = dif.out_valid && !dif.out_ready;
      if (rom_en) begin
        checkOutput("rom_read_expected", exp_rom_q.size() != 0, 1);
        if (exp_rom_q.size() != 0) checkOutput("rom_addr", rom_addr, exp_rom_q.pop_front());
        last_rom = rom_addr;
      end
      if (done) done_cnt++;
    end else begin
      prev_stall = 0;
    end
  end

  // Reference: walk each kernel's CSR word row by row with plain integers.
  task automatic buildModel(input logic [6:0] kf, input logic [6:0] kl, input logic [11:0] b,
                            output int n, output int cycles);
    int    eff;
    int    j;
    int    nk;
    int    p[6];
    logic [11:0] bb;
    desc_t d;
    eff = (kl < kf) ? int'(kf) : int'(kl);
    if (eff > NUM_K - 1) eff = NUM_K - 1;
    bb = b;
    n = 0;
    cycles = 1;
    for (int k = int'(kf); k <= eff; k++) begin
      for (int i = 0; i < 6; i++) p[i] = int'(rom_mem[k][47-8*i -: 8]);
      exp_rom_q.push_back(7'(k));
      j = p[0];
      nk = 0;
      for (int r = 0; r < 5; r++) begin
        while (j < p[r+1]) begin
          d.addr   = bb + 12'(j);
          d.row    = 3'(r);
          d.kernel = 7'(k);
          d.lir    = (j == p[r+1] - 1);
          d.lik    = (j == p[5] - 1);
          exp_q.push_back(d);
          j++;
          nk++;
        end
      end
      n += nk;
      cycles += 8 + nk;
      bb = bb + 12'(p[5]);
    end
  endtask

  function automatic logic readyFor(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c >= 6 && c < 10) ? 1'b0 : (c % 2 == 0);
    return $urandom_range(0, 3) != 0;
  endfunction

  // Runs one range from an IDLE, post-edge starting point; returns observed stats.
  task automatic applyStimulus(input logic [6:0] kf, input logic [6:0] kl, input logic [11:0] b,
                               input int mode, input bit noise,
                               output int n_obs, output int done_cyc, output int first_valid);
    int exp_n;
    int exp_done;
    int cyc;
    bit busy_ok;
    exp_q.delete();
    exp_rom_q.delete();
    obs_q.delete();
    n_hs = 0;
    done_cnt = 0;
    buildModel(kf, kl, b, exp_n, exp_done);
    kernel_first = kf;
    kernel_last = kl;
    base_addr = b;
    start = 1'b1;
    out_ready_drive(readyFor(mode, 0));
    cyc = 0;
    done_cyc = -1;
    first_valid = -1;
    busy_ok = 1;
    while (cyc < 20000) begin
      @(negedge clk);
      if (cyc == 0 && busy !== 1'b0) busy_ok = 0;
      if (cyc > 0 && busy !== 1'b1) busy_ok = 0;
      if (dif.out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (noise && cyc == 4) begin
        start = 1'b1;
        kernel_first = 7'($urandom);
        kernel_last = 7'($urandom);
        base_addr = 12'($urandom);
      end
      out_ready_drive(readyFor(mode, cyc));
    end
    start = 1'b0;
    checkOutput("done_seen", done_cyc >= 0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("busy_window", busy_ok, 1);
    checkOutput("model_count", n_hs, exp_n);
    checkOutput("leftover_desc", exp_q.size(), 0);
    checkOutput("leftover_rom", exp_rom_q.size(), 0);
    checkOutput("done_pulses", done_cnt, 1);
    if (mode == 0) checkOutput("model_done_cycle", done_cyc, exp_done);
    n_obs = n_hs;
    @(posedge clk);
    #1;
  endtask

  task automatic out_ready_drive(input logic v);
    dif.out_ready = v;
  endtask

  vec_t vecs[8];
  int   n;
  int   dc;
  int   fv;
  int   fa;
  int   exp_rows[6] = '{0, 1, 1, 1, 3, 4};
  int   exp_lir[6] = '{1, 0, 0, 1, 1, 1};
  int   exp_lik[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    int p[6];
    logic [6:0] kf;
    logic [6:0] kl;
    int sel;

    rst = 1'b1;
    start = 1'b0;
    kernel_first = '0;
    kernel_last = '0;
    base_addr = '0;
    dif.out_ready = 1'b0;

    for (int k = 0; k < 128; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 6; i++) p[i] = $urandom_range(0, 15);
      end else begin
        p[0] = $urandom_range(0, 3);
        for (int i = 1; i < 6; i++) p[i] = p[i-1] + $urandom_range(0, 4);
      end
      rom_mem[k] = {8'(p[0]), 8'(p[1]), 8'(p[2]), 8'(p[3]), 8'(p[4]), 8'(p[5])};
    end
    rom_mem[0]   = {8'd0, 8'd1, 8'd4, 8'd4, 8'd5, 8'd6};
    rom_mem[1]   = {8'd0, 8'd0, 8'd0, 8'd2, 8'd3, 8'd3};
    rom_mem[2]   = {8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    rom_mem[3]   = 48'd0;
    rom_mem[4]   = {8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    rom_mem[5]   = {8'd0, 8'd3, 8'd1, 8'd2, 8'd5, 8'd5};
    rom_mem[100] = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    rom_mem[101] = {8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};

    // first, last, base, ready mode, count, done cycle, first addr, first valid, last rom addr
    vecs[0] = '{7'd0,   7'd0,   12'd0,    0, 6,  15, 0,    3,  0};
    vecs[1] = '{7'd0,   7'd2,   12'd100,  0, 10, 35, 100,  3,  2};
    vecs[2] = '{7'd2,   7'd0,   12'd5,    0, 1,  10, 5,    3,  2};
    vecs[3] = '{7'd3,   7'd4,   12'd50,   0, 1,  18, 50,   11, 4};
    vecs[4] = '{7'd100, 7'd127, 12'd0,    0, 7,  24, 0,    3,  101};
    vecs[5] = '{7'd5,   7'd5,   12'd10,   0, 5,  14, 10,   3,  5};
    vecs[6] = '{7'd0,   7'd0,   12'd0,    1, 6,  -1, 0,    3,  0};
    vecs[7] = '{7'd0,   7'd2,   12'd4090, 1, 10, -1, 4090, 3,  2};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].first, vecs[i].last, vecs[i].base, vecs[i].mode, 1'b0, n, dc, fv);
      checkOutput($sformatf("v%0d_count", i), n, vecs[i].exp_count);
      if (vecs[i].exp_done >= 0) checkOutput($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
      checkOutput($sformatf("v%0d_first_valid", i), fv, vecs[i].exp_first_valid);
      fa = -1;
      if (obs_q.size() > 0) fa = int'(obs_q[0].addr);
      checkOutput($sformatf("v%0d_first_addr", i), fa, vecs[i].exp_first_addr);
      checkOutput($sformatf("v%0d_last_rom", i), last_rom, vecs[i].exp_last_rom);
      if (i == 0 && obs_q.size() == 6) begin
        for (int e = 0; e < 6; e++) begin
          checkOutput($sformatf("v0_addr%0d", e), obs_q[e].addr, e);
          checkOutput($sformatf("v0_row%0d", e), obs_q[e].row, exp_rows[e]);
          checkOutput($sformatf("v0_lir%0d", e), obs_q[e].lir, exp_lir[e]);
          checkOutput($sformatf("v0_lik%0d", e), obs_q[e].lik, exp_lik[e]);
        end
      end
      if (i == 1 && obs_q.size() == 10) begin
        for (int e = 6; e < 10; e++) checkOutput($sformatf("v1_addr%0d", e), obs_q[e].addr, 100 + e);
        checkOutput("v1_k2_row", obs_q[9].row, 0);
        checkOutput("v1_k2_kernel", obs_q[9].kernel, 2);
      end
    end

    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 9);
      kf = 7'($urandom_range(0, NUM_K - 1));
      if (sel < 6) begin
        kl = kf + 7'($urandom_range(0, 3));
      end else if (sel < 8) begin
        kl = 7'($urandom_range(0, int'(kf)));
      end else begin
        kf = 7'($urandom_range(90, NUM_K - 1));
        kl = 7'd127;
      end
      applyStimulus(kf, kl, 12'($urandom_range(0, 4095)), ($urandom_range(0, 1) == 0) ? 0 : 2,
                    1'($urandom_range(0, 1)), n, dc, fv);
    end

    // Reset in the middle of kernel 0's row 1, then a fresh start.
    mon_en = 1'b0;
    exp_q.delete();
    exp_rom_q.delete();
    kernel_first = 7'd0;
    kernel_last = 7'd0;
    base_addr = 12'd0;
    dif.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre_reset_valid", dif.out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("mid_rst");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput($sformatf("post_rst_done%0d", c), done, 0);
      checkOutput($sformatf("post_rst_busy%0d", c), busy, 0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    applyStimulus(7'd0, 7'd0, 12'd0, 0, 1'b1, n, dc, fv);
    checkOutput("restart_count", n, 6);
    checkOutput("restart_done_cycle", dc, 15);
    checkOutput("restart_first_valid", fv, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
